// File: rtl/pdm_audio_pkg.sv
// Shared types and constants for the PDM audio transmitter.
// PCM samples are signed 16-bit; the modulator works on offset-binary values.
package pdm_audio_pkg;

  localparam int PCM_W = 16;
  localparam logic [PCM_W-1:0] MIDSCALE = 16'h8000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Flipping the sign bit maps -32768..32767 onto 0..65535.
  function automatic logic [PCM_W-1:0] to_offset_binary(input logic [PCM_W-1:0] sample);
    return sample ^ MIDSCALE;
  endfunction

endpackage

// File: rtl/pdm_audio_tx_if.sv
// PCM sample stream into the transmitter.
// A sample transfers on a rising clock edge where s_valid && s_ready; the master holds s_data/s_valid until then.
interface pdm_audio_tx_if;
  import pdm_audio_pkg::*;

  logic [PCM_W-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/pdm_sample_fifo.sv
// Synchronous sample FIFO with level counter; push/pop are ignored when full/empty.
// Head entry is shown combinationally on dout.
module pdm_sample_fifo
  import pdm_audio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [PCM_W-1:0]       din,
  input  logic                   pop,
  output logic [PCM_W-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [PCM_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pdm_audio_tx.sv
// PCM-to-PDM transmitter: first-order sigma-delta on offset-binary samples,
// one PDM bit per CLK_DIV clocks, OSR bits per sample, fed from a sample FIFO.
module pdm_audio_tx
  import pdm_audio_pkg::*;
#(
  parameter int CLK_DIV    = 32,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk_100MHz,
  input  logic                        sysreset_n,
  input  logic                        enable,
  pdm_audio_tx_if.slave               pcm,
  output logic                        pdm_out,
  output logic                        pdm_clk,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output state_t                      state
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(OSR);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(OSR - 1);

  logic [DW-1:0]    div_cnt;
  logic [DW-1:0]    div_next;
  logic [BW-1:0]    bit_cnt;
  logic [PCM_W-1:0] acc;
  logic [PCM_W-1:0] u;
  logic [PCM_W:0]   sum;
  logic [PCM_W-1:0] head;
  logic             ready_en;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             tick;
  logic             boundary;

  // s_ready stays low through reset and rises on the first clock after release.
  always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
    if (!sysreset_n) ready_en <= 1'b0;
    else             ready_en <= 1'b1;
  end

  assign pcm.s_ready = ready_en && !fifo_full;
  assign push        = pcm.s_valid && pcm.s_ready;
  assign tick        = (div_cnt == DIV_LAST);
  assign boundary    = tick && (bit_cnt == BIT_LAST);
  assign div_next    = tick ? '0 : div_cnt + 1'b1;
  assign sum         = {1'b0, acc} + {1'b0, u};
  assign pop         = enable && !fifo_empty && ((state == IDLE) || (state == RUN && boundary));

  pdm_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_100MHz),
    .rst_n (sysreset_n),
    .push  (push),
    .din   (pcm.s_data),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      acc      <= '0;
      u        <= MIDSCALE;
      pdm_out  <= 1'b0;
      pdm_clk  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          acc     <= '0;
          pdm_out <= 1'b0;
          pdm_clk <= 1'b0;
          if (enable && !fifo_empty) begin
            state <= RUN;
            u     <= to_offset_binary(head);
          end
        end
        RUN: begin
          if (!enable) begin
            // The sample in flight is dropped; queued samples stay in the FIFO.
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            acc     <= '0;
            pdm_out <= 1'b0;
            pdm_clk <= 1'b0;
          end else begin
            div_cnt <= div_next;
            pdm_clk <= (div_next >= DIV_HALF);
            if (tick) begin
              {pdm_out, acc} <= sum;
              bit_cnt        <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
              if (boundary) begin
                if (!fifo_empty) begin
                  u <= to_offset_binary(head);
                end else begin
                  // Starved: play silence and keep the accumulator phase.
                  u        <= MIDSCALE;
                  underrun <= 1'b1;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
